// File: rtl/mu0_ctrl_pkg.sv
// rtl/mu0_ctrl_pkg.sv - MU0 control sequencer shared opcodes, state encodings and decode vector
package mu0_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC1 = 3'd2,
    ST_EXEC2 = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JMI = 4'b0101;
  localparam logic [3:0] OP_JEQ = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_LSL = 4'b1001;
  localparam logic [3:0] OP_LSR = 4'b1010;
  localparam logic [3:0] OP_FBC = 4'b1100;
  localparam logic [3:0] OP_RND = 4'b1101;
  localparam logic [3:0] OP_LNK = 4'b1110;

  // One bit per legal opcode; an all-zero vector means the opcode is illegal.
  typedef struct packed {
    logic lda;
    logic sta;
    logic add;
    logic sub;
    logic jmp;
    logic jmi;
    logic jeq;
    logic stp;
    logic ldi;
    logic lsl;
    logic lsr;
    logic fbc;
    logic rnd;
    logic lnk;
  } op_vec_t;

endpackage

// File: rtl/mu0_op_decode.sv
// rtl/mu0_op_decode.sv - combinational opcode to one-hot decode with legality bit
module mu0_op_decode
  import mu0_ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter bit EXT_EN = 1'b1
) (
  input  logic [OP_W-1:0] op,
  output op_vec_t         dec,
  output logic            legal
);

  logic       hi_zero;
  logic [3:0] nib;

  always_comb begin
    hi_zero = ((op >> 4) == '0);
    nib     = op[3:0];
    dec     = '0;
    if (hi_zero) begin
      case (nib)
        OP_LDA:  dec.lda = 1'b1;
        OP_STA:  dec.sta = 1'b1;
        OP_ADD:  dec.add = 1'b1;
        OP_SUB:  dec.sub = 1'b1;
        OP_JMP:  dec.jmp = 1'b1;
        OP_JMI:  dec.jmi = 1'b1;
        OP_JEQ:  dec.jeq = 1'b1;
        OP_STP:  dec.stp = 1'b1;
        OP_LDI:  dec.ldi = 1'b1;
        OP_LSL:  dec.lsl = 1'b1;
        OP_LSR:  dec.lsr = 1'b1;
        OP_FBC:  dec.fbc = EXT_EN;
        OP_RND:  dec.rnd = EXT_EN;
        OP_LNK:  dec.lnk = EXT_EN;
        default: dec = '0;
      endcase
    end
    legal = |dec;
  end

endmodule

// File: rtl/mu0_ctrl_sequencer.sv
// rtl/mu0_ctrl_sequencer.sv - MU0 control unit with own FETCH/EXEC sequencing, wait stretching and retire count
module mu0_ctrl_sequencer
  import mu0_ctrl_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int CNT_W    = 16,
  parameter bit EXT_EN   = 1'b1,
  parameter bit WAIT_EN  = 1'b1,
  parameter bit TRAP_ILL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             resume,
  input  logic [OP_W-1:0]  op,
  input  logic             eq,
  input  logic             mi,
  input  logic             mem_ready,
  output logic             pc_sload,
  output logic             pc_cnt_en,
  output logic             mux1_sel,
  output logic             mux2_sel,
  output logic             mux3_sel,
  output logic             ir_en,
  output logic             ram_wren,
  output logic             shiftreg_en,
  output logic             shiftreg_load,
  output logic             alu_add_sub,
  output logic             fbc_check,
  output logic             rnd_check,
  output logic             lnk_check,
  output logic [STATE_W-1:0] state_o,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             rdy;
  op_vec_t          dec;
  logic             legal;
  logic             is_fetch, is_exec1, is_exec2;
  logic             nop_ill;

  mu0_op_decode #(
    .OP_W   (OP_W),
    .EXT_EN (EXT_EN)
  ) u_decode (
    .op    (op),
    .dec   (dec),
    .legal (legal)
  );

  assign rdy = mem_ready | !WAIT_EN;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (rdy) state_d = ST_EXEC1;
      end
      ST_EXEC1: begin
        if (rdy) begin
          if (dec.lda || dec.add || dec.sub) begin
            state_d = ST_EXEC2;
          end else if (dec.stp) begin
            state_d = ST_HALT;
            retire  = 1'b1;
          end else if (!legal && TRAP_ILL) begin
            // A trapped opcode never completed, so it is not counted.
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end
      end
      ST_EXEC2: begin
        if (rdy) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_d   = ST_FETCH;
          illegal_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    is_fetch = (state_q == ST_FETCH);
    is_exec1 = (state_q == ST_EXEC1);
    is_exec2 = (state_q == ST_EXEC2);
    nop_ill  = !legal && !TRAP_ILL;

    mux1_sel    = is_fetch | (is_exec1 & (dec.jmp | dec.jmi | dec.jeq | dec.stp |
                                          dec.ldi | dec.lsl | dec.lsr));
    mux2_sel    = is_exec1;
    mux3_sel    = is_exec2 & (dec.add | dec.sub);
    alu_add_sub = is_exec2 & dec.add;
    fbc_check   = EXT_EN & is_exec1 & dec.fbc;
    rnd_check   = EXT_EN & is_exec1 & dec.rnd;
    lnk_check   = EXT_EN & is_exec1 & dec.lnk;

    // Writes and loads only fire on the ready cycle so each happens once per phase.
    ir_en     = is_exec1 & rdy;
    ram_wren  = is_exec1 & rdy & dec.sta;
    pc_sload  = is_exec1 & rdy & (dec.jmp | (dec.jmi & mi) | (dec.jeq & eq));
    pc_cnt_en = is_exec1 & rdy & (dec.lda | dec.sta | dec.add | dec.sub |
                                  dec.ldi | dec.lsl | dec.lsr |
                                  (dec.jmi & !mi) | (dec.jeq & !eq) |
                                  dec.fbc | dec.rnd | dec.lnk | nop_ill);
    shiftreg_en   = rdy & ((is_exec1 & (dec.ldi | dec.lsl | dec.lsr)) |
                           (is_exec2 & (dec.lda | dec.add | dec.sub)));
    shiftreg_load = rdy & ((is_exec1 & dec.ldi) |
                           (is_exec2 & (dec.lda | dec.add | dec.sub)));

    state_o = state_q;
    halted  = (state_q == ST_HALT);
    illegal = illegal_q;
    retired = retired_q;
  end

endmodule
